// File: rtl/fft_seq_ctrl_if.sv
// Handshake and control bundle between an FFT sequencer and its datapath/host.
// The master drives the frame request and sample-valid; the slave (the controller)
// returns flow control, stage selects and frame status.
interface fft_seq_ctrl_if #(
    parameter int unsigned STAGES = 4
);
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic              busy;
    logic [STAGES-2:0] sel_1;
    logic [STAGES-2:0] sel_2;
    logic              out_valid;
    logic              out_last;
    logic              frame_done;
    logic              err;

    modport master (
        output start, in_valid,
        input  in_ready, busy, sel_1, sel_2, out_valid, out_last, frame_done, err
    );

    modport slave (
        input  start, in_valid,
        output in_ready, busy, sel_1, sel_2, out_valid, out_last, frame_done, err
    );
endinterface

// File: rtl/fft_seq_ctrl.sv
// Frame sequencer for a pipelined radix-2 FFT: accepts POINTS/2 sample pairs on
// consecutive cycles, drives per-stage rotator and commutator selects, and flags
// the output window. All outputs are registered; each register is loaded with the
// value belonging to the phase the pipeline enters on the next cycle.
module fft_seq_ctrl #(
    parameter int unsigned POINTS    = 16,
    parameter int unsigned STAGES    = 4,
    parameter int unsigned STAGE_LAT = 3,
    parameter int unsigned ROT_LAT   = 1,
    parameter int unsigned TOTAL_LAT = 12
) (
    input logic           clk,
    input logic           reset,
    fft_seq_ctrl_if.slave bus
);
    localparam int unsigned HALF = POINTS / 2;
    localparam int unsigned LAST = TOTAL_LAT + HALF - 1;
    localparam int unsigned PW   = $clog2(TOTAL_LAT + HALF + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t            state;
    logic [PW-1:0]     p;
    logic              started;
    logic              in_ready;
    logic              busy;
    logic [STAGES-2:0] sel_1;
    logic [STAGES-2:0] sel_2;
    logic              out_valid;
    logic              out_last;
    logic              frame_done;
    logic              err;

    // Stage k sees the frame (k-1)*STAGE_LAT cycles later; its select walks
    // from the MSB-side bit at stage 1 down to bit 0 at the last commutated stage.
    function automatic logic [STAGES-2:0] sel_at(input int ph);
        logic [STAGES-2:0] s;
        int                q;
        s = '0;
        for (int k = 1; k < int'(STAGES); k++) begin
            q = ph - (k - 1) * int'(STAGE_LAT);
            if (q >= 0 && q < int'(HALF)) begin
                s[k-1] = q[int'(STAGES) - 1 - k];
            end
        end
        return s;
    endfunction

    logic [PW-1:0]     p_nxt;
    logic [STAGES-2:0] sel_1_nxt;
    logic [STAGES-2:0] sel_2_nxt;
    logic              ov_nxt;
    logic              last_nxt;

    // Output values for the phase reached after this cycle's advance.
    assign p_nxt     = p + PW'(1);
    assign sel_1_nxt = sel_at(int'(p_nxt));
    assign sel_2_nxt = sel_at(int'(p_nxt) - int'(ROT_LAT));
    assign ov_nxt    = (int'(p_nxt) >= int'(TOTAL_LAT)) && (int'(p_nxt) <= int'(LAST));
    assign last_nxt  = (int'(p_nxt) == int'(LAST));

    // Frame FSM with registered outputs; abort and frame end both fall back to a
    // quiet IDLE with every select and valid cleared.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            p          <= '0;
            started    <= 1'b0;
            in_ready   <= 1'b0;
            busy       <= 1'b0;
            sel_1      <= '0;
            sel_2      <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        state    <= RUN;
                        p        <= '0;
                        started  <= 1'b0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        err      <= 1'b0;
                    end
                end
                RUN: begin
                    if (started && !bus.in_valid) begin
                        // Broken sample stream: drop the frame and latch the error.
                        state      <= IDLE;
                        p          <= '0;
                        started    <= 1'b0;
                        in_ready   <= 1'b0;
                        busy       <= 1'b0;
                        sel_1      <= '0;
                        sel_2      <= '0;
                        out_valid  <= 1'b0;
                        out_last   <= 1'b0;
                        frame_done <= 1'b0;
                        err        <= 1'b1;
                    end else if (bus.in_valid) begin
                        started    <= 1'b1;
                        p          <= p_nxt;
                        sel_1      <= sel_1_nxt;
                        sel_2      <= sel_2_nxt;
                        out_valid  <= ov_nxt;
                        out_last   <= last_nxt;
                        frame_done <= last_nxt;
                        if (int'(p) == int'(HALF) - 1) begin
                            state    <= DRAIN;
                            in_ready <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (int'(p) == int'(LAST)) begin
                        state      <= IDLE;
                        p          <= '0;
                        started    <= 1'b0;
                        busy       <= 1'b0;
                        sel_1      <= '0;
                        sel_2      <= '0;
                        out_valid  <= 1'b0;
                        out_last   <= 1'b0;
                        frame_done <= 1'b0;
                    end else begin
                        p          <= p_nxt;
                        sel_1      <= sel_1_nxt;
                        sel_2      <= sel_2_nxt;
                        out_valid  <= ov_nxt;
                        out_last   <= last_nxt;
                        frame_done <= last_nxt;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.busy       = busy;
    assign bus.sel_1      = sel_1;
    assign bus.sel_2      = sel_2;
    assign bus.out_valid  = out_valid;
    assign bus.out_last   = out_last;
    assign bus.frame_done = frame_done;
    assign bus.err        = err;
endmodule

// File: doc/fft_seq_ctrl.md
FFT_SEQ_CTRL -- requirements
Module: fft_seq_ctrl

Interface
REQ-001 The block SHALL have these parameters:
- POINTS, default 16: FFT size (power of 2, at least 8).
- STAGES, default 4: log2(POINTS).
- STAGE_LAT, default 3: input-to-input latency between adjacent stages, in cycles.
- ROT_LAT, default 1: rotator latency, from sel_1 to sel_2.
- TOTAL_LAT, default 12: cycles from the first accepted sample pair to the first output pair.

REQ-002 The block SHALL have these ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  frame request pulse; honoured only in IDLE.
- in_valid  in  1  sample pair present on line1/line2.
- in_ready  out  1  controller accepts sample pairs.
- busy  out  1  high in any state other than IDLE.
- sel_1  out  STAGES-1  per-stage twiddle/rotator phase; bit k-1 drives commutated stage k.
- sel_2  out  STAGES-1  per-stage output commutator mux select.
- out_valid  out  1  pipeline output pair valid.
- out_last  out  1  last output pair of the frame.
- frame_done  out  1  one-cycle completion pulse.
- err  out  1  sticky protocol error flag.

Function
REQ-003 The FSM SHALL have states IDLE, RUN and DRAIN; all outputs SHALL be registered.

REQ-004 IDLE: in_ready=0; start=1 SHALL move the FSM to RUN next cycle and clear err.

REQ-005 RUN: in_ready=1; the FSM waits indefinitely for the first in_valid=1; cycle c=0 is the cycle in which in_valid and in_ready are both high for the first time.

REQ-006 RUN: sample pairs c=0..POINTS/2-1 SHALL arrive on consecutive cycles.
- in_valid=0 at any c in 1..POINTS/2-1 sets err=1 and returns the FSM to IDLE next cycle.
- On abort, all sel outputs, out_valid and out_last go to 0.

REQ-007 In the cycle that accepts c=POINTS/2-1, the FSM SHALL move to DRAIN and drive in_ready=0 from the next cycle; in_valid outside RUN SHALL be ignored with no error.

REQ-008 A phase counter p SHALL equal c, starting at 0 at c=0 and incrementing every cycle through RUN and DRAIN; its width is sufficient for TOTAL_LAT+POINTS/2 without wrapping.

REQ-009 For commutated stage k (1..STAGES-1), the local phase SHALL be q_k = p-(k-1)*STAGE_LAT.
- sel_1[k-1] = bit (STAGES-1-k) of q_k while 0 <= q_k < POINTS/2; 0 otherwise.
- For POINTS=16: stage1 toggles every 4 cycles, stage2 every 2, stage3 every 1.

REQ-010 sel_2[k-1] SHALL equal sel_1[k-1] delayed by exactly ROT_LAT cycles, and 0 outside that delayed window.

REQ-011 out_valid SHALL be high for exactly POINTS/2 consecutive cycles, c=TOTAL_LAT .. TOTAL_LAT+POINTS/2-1.
- out_last and frame_done are high only at c=TOTAL_LAT+POINTS/2-1.
- The FSM returns to IDLE the following cycle.

REQ-012 start received in RUN or DRAIN SHALL be ignored; there is no queuing, so the next frame requires a new start in IDLE.

REQ-013 Simultaneous start and reset: reset wins.

REQ-014 err SHALL remain set until the next accepted start or reset.

Reset
REQ-015 reset=1 at any clock edge SHALL force, on the next cycle:
- state=IDLE, p=0, err=0;
- in_ready, busy, sel_1, sel_2, out_valid, out_last and frame_done all 0.

REQ-016 Reset mid-frame SHALL abandon the frame without asserting frame_done or err.

Verification (defaults: POINTS=16, STAGE_LAT=3, ROT_LAT=1, TOTAL_LAT=12)
REQ-017 Nominal frame: start, then in_valid high for 8 cycles from c=0.
- sel_1[0]=0,0,0,0,1,1,1,1 over c=0..7.
- sel_1[1]=0,0,1,1,0,0,1,1 over c=3..10.
- sel_1[2]=0,1,0,1,0,1,0,1 over c=6..13.
- sel_2 equals the same patterns shifted +1 cycle.
- out_valid high c=12..19; out_last and frame_done at c=19; busy=0 at c=20.

REQ-018 Gap: in_valid=0 at c=5 -> err=1 and IDLE at c=6; no out_valid; a new start clears err.

REQ-019 Late data: start, then in_valid held low for 10 cycles -> no err, in_ready stays 1, and the frame completes normally relative to the first in_valid.

REQ-020 Ignored start: start pulsed at c=4 and at c=15 -> single frame, one frame_done only.

REQ-021 Mid-frame reset: reset at c=9 -> all outputs 0 next cycle, no frame_done; a subsequent start runs a clean frame.

REQ-022 Back-to-back: start asserted the cycle after frame_done -> second frame timing is identical to REQ-017.
